// File: rtl/nonce_dispatch_pkg.sv
// Shared definitions for the nonce dispatcher and the Blake2b compare stage.
package nonce_dispatch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StRun   = 2'd1;
  localparam state_t StDrain = 2'd2;
  localparam state_t StDone  = 2'd3;

  localparam logic [63:0] Blake2bIv0 = 64'h6a09e667f3bcc908;

  // The core hashes the nonce little-endian; the compare stage reverses it with this same helper.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/nonce_dispatch_result_fifo.sv
// First-word-fall-through result FIFO; head reads as zero while empty.
module result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the head slot in the same cycle, so a full FIFO can still accept a push.
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + PtrOne;
    if (do_pop)  rd_d = rd_q + PtrOne;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/nonce_dispatch.sv
// Feeds candidate nonces into the Blake2b core and queues winning nonces for the host.
// Build option NONCE_DISPATCH_STOP_ON_FOUND_EN: a qualified found while running acts as abort.
module nonce_dispatch
  import nonce_dispatch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned INFLIGHT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] nonce_base,
  input  logic [31:0] nonce_count,
  input  logic [31:0] m04_hi,
  input  logic        core_ready,
  output logic        valid,
  output logic [63:0] m04,
  input  logic        cmp_busy,
  input  logic        cmp_found,
  input  logic [31:0] cmp_nonce,
  output logic        res_valid,
  output logic [31:0] res_nonce,
  input  logic        res_rd,
  output logic        overflow,
  output logic        running,
  output logic        done
);

  localparam logic [INFLIGHT_W-1:0] InflightOne = {{(INFLIGHT_W-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [31:0]           cur_q, cur_d;
  logic [31:0]           rem_q, rem_d;
  logic [31:0]           hi_q, hi_d;
  logic                  valid_q, valid_d;
  logic [63:0]           m04_q, m04_d;
  logic                  ovf_q, ovf_d;
  logic [INFLIGHT_W-1:0] inflight_q, inflight_d;

  logic issue, found, stop_req, pop, fifo_full, fifo_empty;

  assign issue = valid_q & core_ready;
  assign found = cmp_busy & cmp_found;
  assign pop   = res_rd & ~fifo_empty;

`ifdef NONCE_DISPATCH_STOP_ON_FOUND_EN
  assign stop_req = abort | found;
`else
  assign stop_req = abort;
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    valid_d = valid_q;
    m04_d   = m04_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          cur_d = nonce_base;
          rem_d = nonce_count;
          hi_d  = m04_hi;
          ovf_d = 1'b0;
          if (nonce_count == '0) begin
            state_d = StDrain;
          end else begin
            state_d = StRun;
            valid_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (issue) begin
          cur_d = cur_q + 32'd1;
          rem_d = rem_q - 32'd1;
        end
        if ((issue && rem_q == 32'd1) || stop_req) begin
          state_d = StDrain;
          valid_d = 1'b0;
        end
      end
      StDrain: begin
        if (inflight_q == '0 && !cmp_busy) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
    // m04 is refreshed only while a candidate is presented, so it holds across stalls.
    if (state_d == StRun) m04_d = {hi_d, bswap32(cur_d)};
    if (found && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !cmp_busy) begin
      inflight_d = inflight_q + InflightOne;
    end else if (!issue && cmp_busy && inflight_q != '0) begin
      inflight_d = inflight_q - InflightOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      rem_q      <= '0;
      hi_q       <= '0;
      valid_q    <= 1'b0;
      m04_q      <= '0;
      ovf_q      <= 1'b0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      rem_q      <= rem_d;
      hi_q       <= hi_d;
      valid_q    <= valid_d;
      m04_q      <= m04_d;
      ovf_q      <= ovf_d;
      inflight_q <= inflight_d;
    end
  end

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_result_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (found),
    .pop_i   (res_rd),
    .data_i  (cmp_nonce),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (res_nonce)
  );

  assign valid     = valid_q;
  assign m04       = m04_q;
  assign res_valid = ~fifo_empty;
  assign overflow  = ovf_q;
  assign running   = (state_q == StRun) || (state_q == StDrain);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_nonce_dispatch.sv
// Scoreboard bench for nonce_dispatch: a queue-based range/FIFO model plus a fake in-order core.
module tb_nonce_dispatch;

  localparam int FifoDepth = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [31:0] nonce_base, nonce_count, m04_hi;
  logic        core_ready, valid;
  logic [63:0] m04;
  logic        cmp_busy, cmp_found;
  logic [31:0] cmp_nonce;
  logic        res_valid, res_rd, overflow, running, done;
  logic [31:0] res_nonce;

  nonce_dispatch #(
    .FIFO_DEPTH (FifoDepth),
    .INFLIGHT_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .nonce_base  (nonce_base),
    .nonce_count (nonce_count),
    .m04_hi      (m04_hi),
    .core_ready  (core_ready),
    .valid       (valid),
    .m04         (m04),
    .cmp_busy    (cmp_busy),
    .cmp_found   (cmp_found),
    .cmp_nonce   (cmp_nonce),
    .res_valid   (res_valid),
    .res_nonce   (res_nonce),
    .res_rd      (res_rd),
    .overflow    (overflow),
    .running     (running),
    .done        (done)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_m04[$];   // nonces still to be issued
  logic [31:0] core_q[$];    // nonces inside the fake core
  logic [31:0] exp_res[$];   // expected result FIFO contents
  logic        exp_ovf = 1'b0;
  logic [31:0] hi_m = '0;
  int          n_issued = 0;
  bit          run_at_drv = 1'b0;
  int          rdy_mode = 0, ret_pct = 100, found_pct = 0, rd_pct = 0, pat_idx = 0;
  bit          rdy_pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  function automatic logic [31:0] swap_bytes(input logic [31:0] n);
    return {n[7:0], n[15:8], n[23:16], n[31:24]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (rst == 1'b0) begin
      chk("valid", valid, exp_m04.size() > 0);
      if (exp_m04.size() > 0) chk("running", running, 1'b1);
      chk("run_done_excl", running & done, 1'b0);
      if (done) chk("done_early", exp_m04.size() + core_q.size(), 0);
      if (valid && exp_m04.size() > 0) begin
        chk("m04", m04, {hi_m, swap_bytes(exp_m04[0])});
        if (core_ready) begin
          core_q.push_back(exp_m04.pop_front());
          n_issued++;
        end
      end
      chk("res_valid", res_valid, exp_res.size() > 0);
      if (exp_res.size() > 0) chk("res_nonce", res_nonce, exp_res[0]);
      chk("overflow", overflow, exp_ovf);
    end
  end

  // Consume the cycle just ended into the model, then drive the next cycle.
  task automatic step();
    int sz;
    bit popped, stop;
    @(posedge clk);
    if (!rst) begin
      if (start) begin
        exp_ovf = 1'b0;
        hi_m    = m04_hi;
        for (int i = 0; i < int'(nonce_count); i++) exp_m04.push_back(nonce_base + 32'(i));
      end
      stop = abort;
`ifdef NONCE_DISPATCH_STOP_ON_FOUND_EN
      stop = stop | (cmp_busy & cmp_found);
`endif
      if (stop && run_at_drv) exp_m04.delete();
      sz     = exp_res.size();
      popped = 1'b0;
      if (res_rd && sz > 0) begin
        void'(exp_res.pop_front());
        popped = 1'b1;
      end
      if (cmp_busy && cmp_found) begin
        if (sz < FifoDepth || popped) exp_res.push_back(cmp_nonce);
        else exp_ovf = 1'b1;
      end
    end
    #1;
    run_at_drv  = exp_m04.size() > 0;
    start       = 1'b0;
    abort       = 1'b0;
    nonce_base  = $urandom;
    nonce_count = $urandom;
    m04_hi      = $urandom;
    case (rdy_mode)
      0: core_ready = 1'b1;
      1: core_ready = 1'($urandom % 2);
      default: begin
        if (run_at_drv && pat_idx < 6) begin
          core_ready = rdy_pat[pat_idx];
          pat_idx++;
        end else begin
          core_ready = 1'b1;
        end
      end
    endcase
    if (core_q.size() > 0 && ($urandom % 100) < ret_pct) begin
      cmp_busy  = 1'b1;
      cmp_nonce = core_q.pop_front();
      cmp_found = ($urandom % 100) < found_pct;
    end else begin
      cmp_busy  = 1'b0;
      cmp_nonce = $urandom;
      cmp_found = ($urandom % 4) == 0;
    end
    res_rd = ($urandom % 100) < rd_pct;
  endtask

  task automatic launch(input logic [31:0] base, input logic [31:0] cnt, input logic [31:0] hi);
    start       = 1'b1;
    nonce_base  = base;
    nonce_count = cnt;
    m04_hi      = hi;
    step();
  endtask

  task automatic wait_done(input int budget, input int abort_pct);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      if (run_at_drv && ($urandom % 100) < abort_pct) abort = 1'b1;
      n++;
    end
    chk("done_reached", done, 1'b1);
  endtask

  task automatic drain_core(input int budget);
    int n = 0;
    while (core_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk("core_drained", core_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; nonce_base = '0; nonce_count = '0; m04_hi = '0;
    core_ready = 1'b0; cmp_busy = 1'b0; cmp_found = 1'b0; cmp_nonce = '0; res_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid, 1'b0);
    chk("rst_m04", m04, 64'h0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_nonce", res_nonce, 32'h0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_running", running, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    step();

    // Stray return with nothing in flight must not wrap the counter.
    cmp_busy = 1'b1;
    cmp_found = 1'b0;
    step();

    n0 = n_issued;
    launch(32'h0000_0010, 32'd3, 32'hDEAD_BEEF);
    wait_done(100, 0);
    chk("basic_issues", n_issued - n0, 3);

    rdy_mode = 2; pat_idx = 0; n0 = n_issued;
    launch(32'hFFFF_FFFE, 32'd4, 32'h0123_4567);
    wait_done(100, 0);
    chk("wrap_issues", n_issued - n0, 4);
    rdy_mode = 0;

    ret_pct = 0; rd_pct = 0;
    cmp_busy = 1'b1; cmp_found = 1'b1; cmp_nonce = 32'h1234_5678;
    step();
    chk("found_next_cycle", res_valid, 1'b1);
    cmp_busy = 1'b0; cmp_found = 1'b1; cmp_nonce = 32'h0BAD_F00D;
    step();
    chk("found_head", res_nonce, 32'h1234_5678);
    res_rd = 1'b1;
    step();
    step();
    chk("found_popped", res_valid, 1'b0);

    for (int k = 0; k < 5; k++) begin
      cmp_busy = 1'b1; cmp_found = 1'b1; cmp_nonce = 32'hA0 + 32'(k);
      step();
    end
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_head", res_nonce, 32'hA0);
    cmp_busy = 1'b1; cmp_found = 1'b1; cmp_nonce = 32'hA5; res_rd = 1'b1;
    step();
    chk("ovf_sticky", overflow, 1'b1);
    ret_pct = 100;
    launch($urandom, 32'd2, $urandom);
    chk("ovf_cleared", overflow, 1'b0);
    wait_done(100, 0);
    rd_pct = 100;
    repeat (6) step();
    chk("ovf_drained", res_valid, 1'b0);
    rd_pct = 0;

    n0 = n_issued;
    launch($urandom, 32'd100, $urandom);
    while (n_issued - n0 < 2 && n_issued - n0 < 100) step();
    abort = 1'b1;
    wait_done(300, 0);
    chk("abort_issues", n_issued - n0, 3);

    n0 = n_issued;
    launch($urandom, 32'd0, $urandom);
    wait_done(50, 0);
    chk("zero_issues", n_issued - n0, 0);

    rdy_mode = 1; ret_pct = 60; found_pct = 25; rd_pct = 30;
    for (int r = 0; r < 10; r++) begin
      launch($urandom, 32'd1 + ($urandom % 20), $urandom);
      wait_done(800, 3);
    end

    rdy_mode = 0; ret_pct = 0; found_pct = 100; rd_pct = 0;
    cmp_busy = 1'b1; cmp_found = 1'b1; cmp_nonce = 32'hCAFE_0001;
    step();
    launch($urandom, 32'd50, $urandom);
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk("mid_valid", valid, 1'b0);
    chk("mid_m04", m04, 64'h0);
    chk("mid_res_valid", res_valid, 1'b0);
    chk("mid_res_nonce", res_nonce, 32'h0);
    chk("mid_overflow", overflow, 1'b0);
    chk("mid_running", running, 1'b0);
    chk("mid_done", done, 1'b0);
    exp_m04.delete();
    exp_res.delete();
    exp_ovf = 1'b0;
    step();
    rst = 1'b0;
    ret_pct = 100; rd_pct = 50;
    drain_core(200);
    found_pct = 0;
    n0 = n_issued;
    launch($urandom, 32'd5, $urandom);
    wait_done(200, 0);
    chk("post_rst_issues", n_issued - n0, 5);
    rd_pct = 100;
    repeat (8) step();
    chk("end_fifo_empty", res_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
